hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Sequences the PC, IF/ID, ID/EX and later pipeline registers by generating write-enable, flush, bubble and hold controls. Sits beside the ID stage, watching the ID/EX register outputs and the data-memory handshake. Handles load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits, and keeps stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipe_ctrl_pkg;

    // Register index width used by the hazard compares
    localparam int REG_IDX_W = 5;

    // Widths and NOP encodings of the ID/EX control fields zeroed by a bubble
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;
    localparam logic [WB_W-1:0] WB_NOP = '0;
    localparam logic [M_W-1:0]  M_NOP  = '0;
    localparam logic [EX_W-1:0] EX_NOP = '0;

    // Hazard FSM states; encodings are visible on state_o
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    // Bundle of the per-cycle pipeline register controls
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_BUBBLE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_HOLD    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, pipe_hold: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//
// Data-memory handshake: dmem_req_i marks a MEM-stage access in the current
// cycle; the access completes in any cycle where dmem_req_i and dmem_ack_i are
// both high. A request with no ack stalls the pipeline until the ack arrives.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic                 idex_memread_i;
    logic [REG_IDX_W-1:0] idex_rt_i;
    logic [REG_IDX_W-1:0] ifid_rs_i;
    logic [REG_IDX_W-1:0] ifid_rt_i;
    logic                 ifid_uses_rt_i;
    logic                 branch_taken_i;
    logic                 dmem_req_i;
    logic                 dmem_ack_i;
    logic                 pc_write_o;
    logic                 ifid_write_o;
    logic                 ifid_flush_o;
    logic                 idex_bubble_o;
    logic                 pipe_hold_o;
    logic                 mem_err_o;
    logic [CNT_W-1:0]     stall_cnt_o;
    logic [CNT_W-1:0]     flush_cnt_o;
    logic [1:0]           state_o;

    // Datapath side
    modport master (
        output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               mem_err_o, stall_cnt_o, flush_cnt_o, state_o
    );

    // Hazard controller side
    modport slave (
        input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               mem_err_o, stall_cnt_o, flush_cnt_o, state_o
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in ID/EX and the ID sources.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 memread,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    output logic                 lu
);

    // r0 is never a real dependency; rt only matters when ID reads it
    always_comb begin
        lu = memread && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory waits.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALLS   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);

    localparam logic [1:0]  LU_CNT_INIT = 2'(LU_STALLS - 1);
    localparam logic [15:0] WAIT_LIMIT  = 16'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    state_e           resume_q, resume_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu, ms;
    ctrl_t            ctrl;

    hazard_detect u_detect (
        .memread    (bus.idex_memread_i),
        .ex_rt      (bus.idex_rt_i),
        .id_rs      (bus.ifid_rs_i),
        .id_rt      (bus.ifid_rt_i),
        .id_uses_rt (bus.ifid_uses_rt_i),
        .lu         (lu)
    );

    assign ms = bus.dmem_req_i && !bus.dmem_ack_i;

    // State, sequencing counters and the sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            resume_q   <= ST_RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            // Fires on the unanswered wait cycle that brings wait_cnt to the limit
            if (state_q == ST_MEMWAIT && !bus.dmem_ack_i && wait_cnt_d == WAIT_LIMIT)
                mem_err_q <= 1'b1;
        end
    end

    // Next state; the ack cycle out of MEMWAIT is treated as a cycle of the resume state
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ms) begin
                    state_d    = ST_MEMWAIT;
                    resume_d   = ST_RUN;
                    wait_cnt_d = '0;
                end else if (lu) begin
                    lu_cnt_d = LU_CNT_INIT;
                    state_d  = (LU_CNT_INIT != '0) ? ST_LDUSE : ST_RUN;
                end
            end
            ST_LDUSE: begin
                if (ms) begin
                    state_d    = ST_MEMWAIT;
                    resume_d   = ST_LDUSE;
                    wait_cnt_d = '0;
                end else if (lu_cnt_q <= 2'd1) begin
                    lu_cnt_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    lu_cnt_d = lu_cnt_q - 2'd1;
                end
            end
            ST_MEMWAIT: begin
                if (wait_cnt_q != '1)
                    wait_cnt_d = wait_cnt_q + 16'd1;
                if (bus.dmem_ack_i) begin
                    if (resume_q == ST_LDUSE) begin
                        if (lu_cnt_q <= 2'd1) begin
                            lu_cnt_d = '0;
                            state_d  = ST_RUN;
                        end else begin
                            lu_cnt_d = lu_cnt_q - 2'd1;
                            state_d  = ST_LDUSE;
                        end
                    end else if (lu) begin
                        // A hazard that sat behind the memory stall still needs its bubbles
                        lu_cnt_d = LU_CNT_INIT;
                        state_d  = (LU_CNT_INIT != '0) ? ST_LDUSE : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Mealy control outputs; memory stall outranks load-use, which outranks branch flush
    always_comb begin
        ctrl = CTRL_DEFAULT;
        if (!rst_i) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ms)                      ctrl = CTRL_HOLD;
                    else if (lu)                 ctrl = CTRL_BUBBLE;
                    else if (bus.branch_taken_i) ctrl.ifid_flush = 1'b1;
                end
                ST_LDUSE: begin
                    ctrl = ms ? CTRL_HOLD : CTRL_BUBBLE;
                end
                ST_MEMWAIT: begin
                    if (!bus.dmem_ack_i)                    ctrl = CTRL_HOLD;
                    else if (resume_q == ST_LDUSE || lu)    ctrl = CTRL_BUBBLE;
                end
                default: ctrl = CTRL_DEFAULT;
            endcase
        end
    end

    // Saturating performance counters for stalled and flushed cycles
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctrl.pc_write && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ctrl.ifid_flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_write_o    = ctrl.pc_write;
    assign bus.ifid_write_o  = ctrl.ifid_write;
    assign bus.ifid_flush_o  = ctrl.ifid_flush;
    assign bus.idex_bubble_o = ctrl.idex_bubble;
    assign bus.pipe_hold_o   = ctrl.pipe_hold;
    assign bus.mem_err_o     = mem_err_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LU_STALLS=1 and 2) share one stimulus stream.
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 32;

    // Expected control vector {pc_write, ifid_write, flush, bubble, hold, state[1:0]}
    localparam logic [6:0] E_RST     = 7'b0001000;
    localparam logic [6:0] E_RST_MW  = 7'b0001010;
    localparam logic [6:0] E_RUN     = 7'b1100000;
    localparam logic [6:0] E_FLUSH   = 7'b1110000;
    localparam logic [6:0] E_BUB     = 7'b0001000;
    localparam logic [6:0] E_BUB_LD  = 7'b0001001;
    localparam logic [6:0] E_BUB_MW  = 7'b0001010;
    localparam logic [6:0] E_HOLD    = 7'b0000100;
    localparam logic [6:0] E_HOLD_LD = 7'b0000101;
    localparam logic [6:0] E_HOLD_MW = 7'b0000110;
    localparam logic [6:0] E_REL_MW  = 7'b1100010;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Shared stimulus
    logic       memread, uses_rt, br, req, ack;
    logic [4:0] ex_rt, id_rs, id_rt;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus_a ();
    hazard_ctrl_if #(.CNT_W(CNT_W)) bus_b ();

    hazard_ctrl #(.LU_STALLS(1), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a)
    );

    hazard_ctrl #(.LU_STALLS(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.idex_memread_i = memread;
    assign bus_a.idex_rt_i      = ex_rt;
    assign bus_a.ifid_rs_i      = id_rs;
    assign bus_a.ifid_rt_i      = id_rt;
    assign bus_a.ifid_uses_rt_i = uses_rt;
    assign bus_a.branch_taken_i = br;
    assign bus_a.dmem_req_i     = req;
    assign bus_a.dmem_ack_i     = ack;
    assign bus_b.idex_memread_i = memread;
    assign bus_b.idex_rt_i      = ex_rt;
    assign bus_b.ifid_rs_i      = id_rs;
    assign bus_b.ifid_rt_i      = id_rt;
    assign bus_b.ifid_uses_rt_i = uses_rt;
    assign bus_b.branch_taken_i = br;
    assign bus_b.dmem_req_i     = req;
    assign bus_b.dmem_ack_i     = ack;

    logic [6:0] obs_a, obs_b;
    assign obs_a = {bus_a.pc_write_o, bus_a.ifid_write_o, bus_a.ifid_flush_o,
                    bus_a.idex_bubble_o, bus_a.pipe_hold_o, bus_a.state_o};
    assign obs_b = {bus_b.pc_write_o, bus_b.ifid_write_o, bus_b.ifid_flush_o,
                    bus_b.idex_bubble_o, bus_b.pipe_hold_o, bus_b.state_o};

    // Scoreboard
    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected controls of both instances
    task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                        input logic [4:0] irs, input logic [4:0] irt, input logic urt,
                        input logic b, input logic rq, input logic ak,
                        input logic [6:0] ea, input logic [6:0] eb);
        @(posedge clk);
        #1;
        rst_n   = r;
        memread = mr;
        ex_rt   = ert;
        id_rs   = irs;
        id_rt   = irt;
        uses_rt = urt;
        br      = b;
        req     = rq;
        ack     = ak;
        cyc++;
        exp_q.push_back({ea, eb});
    endtask

    task automatic idle(input logic [6:0] ea, input logic [6:0] eb);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
    endtask

    task automatic mem(input logic ak, input logic [6:0] ea, input logic [6:0] eb);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ak, ea, eb);
    endtask

    // Counter / error-flag checks within the current cycle
    task automatic chk_cnt(input string tag, input int sa, input int fa, input int sb, input int fb);
        @(negedge clk);
        check({tag, "_stall_a"}, bus_a.stall_cnt_o, sa);
        check({tag, "_flush_a"}, bus_a.flush_cnt_o, fa);
        check({tag, "_stall_b"}, bus_b.stall_cnt_o, sb);
        check({tag, "_flush_b"}, bus_b.flush_cnt_o, fb);
    endtask

    task automatic chk_err(input string tag, input logic ea, input logic eb);
        @(negedge clk);
        check({tag, "_err_a"}, {31'd0, bus_a.mem_err_o}, {31'd0, ea});
        check({tag, "_err_b"}, {31'd0, bus_b.mem_err_o}, {31'd0, eb});
    endtask

    // Monitor: compare controls against the queued expectation each cycle
    always @(negedge clk) begin : monitor
        logic [13:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cyc%0d_ctrl_a", cyc), {25'd0, obs_a}, {25'd0, e[13:7]});
            check($sformatf("cyc%0d_ctrl_b", cyc), {25'd0, obs_b}, {25'd0, e[6:0]});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; memread = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        uses_rt = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;

        // Reset
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, E_RST);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, E_RST);
        chk_cnt("reset", 0, 0, 0, 0);
        chk_err("reset", 1'b0, 1'b0);
        idle(E_RUN, E_RUN);

        // Load-use on rs
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB, E_BUB);
        idle(E_RUN, E_BUB_LD);
        idle(E_RUN, E_RUN);
        chk_cnt("lu_rs", 1, 0, 2, 0);

        // r0 and unused-rt cases are not hazards; rt hazard when used
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);
        step(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);
        step(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB, E_BUB);
        idle(E_RUN, E_BUB_LD);

        // Branch alone, branch vs load-use, branch during LDUSE
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FLUSH, E_FLUSH);
        step(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_BUB, E_BUB);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FLUSH, E_BUB_LD);
        idle(E_RUN, E_RUN);
        chk_cnt("branch", 3, 2, 6, 1);

        // Load-use with a 3-cycle memory wait starting in the first LDUSE cycle
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB, E_BUB);
        mem(1'b0, E_HOLD, E_HOLD_LD);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        mem(1'b1, E_REL_MW, E_BUB_MW);
        idle(E_RUN, E_RUN);
        chk_cnt("lu_memwait", 7, 2, 11, 1);
        chk_err("lu_memwait", 1'b0, 1'b0);

        // Request acknowledged in the same cycle is not a stall
        mem(1'b1, E_RUN, E_RUN);

        // Timeout: ack low for 6 cycles, then ack
        mem(1'b0, E_HOLD, E_HOLD);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        chk_err("to_before", 1'b0, 1'b0);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        chk_err("to_reach", 1'b1, 1'b1);
        mem(1'b1, E_REL_MW, E_REL_MW);
        chk_err("to_ack", 1'b1, 1'b1);
        idle(E_RUN, E_RUN);
        idle(E_RUN, E_RUN);
        chk_err("to_sticky", 1'b1, 1'b1);

        // Reset in the middle of a memory wait
        mem(1'b0, E_HOLD, E_HOLD);
        mem(1'b0, E_HOLD_MW, E_HOLD_MW);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RST_MW, E_RST_MW);
        idle(E_RUN, E_RUN);
        chk_cnt("rst_mw", 0, 0, 0, 0);
        chk_err("rst_mw", 1'b0, 1'b0);
        idle(E_RUN, E_RUN);
        chk_cnt("after_rst", 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
